// File: rtl/cajero_pkg.sv
// cajero_pkg: shared types for the parametrised ATM controller.
// State encoding and transaction-type constants.
package cajero_pkg;

   typedef enum logic [2:0] {
      ESPERA_TARJETA = 3'd0,
      LEER_PIN       = 3'd1,
      VERIFICAR_PIN  = 3'd2,
      ESPERA_MONTO   = 3'd3,
      TRANSACCION    = 3'd4,
      BLOQUEADO      = 3'd5
   } estado_t;

   localparam logic TIPO_DEPOSITO = 1'b0;
   localparam logic TIPO_RETIRO   = 1'b1;

endpackage

// File: rtl/cajero_param_if.sv
// cajero_param_if: front-end / dispenser bundle of the ATM controller.
// The controller itself uses the slave view.
interface cajero_param_if #(
   parameter int N_DIGITOS     = 4,
   parameter int ANCHO_MONTO   = 32,
   parameter int ANCHO_BALANCE = 64
);

   logic                       TARGETA_RECIBIDA;
   logic [4*N_DIGITOS-1:0]     PIN;
   logic [3:0]                 DIGITO;
   logic                       DIGITO_STB;
   logic                       TIPO_TRANS;
   logic [ANCHO_MONTO-1:0]     MONTO;
   logic                       MONTO_STB;
   logic                       BALANCE_ACTUALIZADO;
   logic                       ENTREGAR_DINERO;
   logic                       PIN_INCORRECTO;
   logic                       FONDOS_INSUFICIENTES;
   logic                       LIMITE_EXCEDIDO;
   logic                       ADVERTENCIA;
   logic                       BLOQUEO;
   logic [ANCHO_BALANCE-1:0]   BALANCE;

   modport master (
      output TARGETA_RECIBIDA, PIN, DIGITO, DIGITO_STB,
      output TIPO_TRANS, MONTO, MONTO_STB,
      input  BALANCE_ACTUALIZADO, ENTREGAR_DINERO,
      input  PIN_INCORRECTO, FONDOS_INSUFICIENTES,
      input  LIMITE_EXCEDIDO, ADVERTENCIA, BLOQUEO, BALANCE
   );

   modport slave (
      input  TARGETA_RECIBIDA, PIN, DIGITO, DIGITO_STB,
      input  TIPO_TRANS, MONTO, MONTO_STB,
      output BALANCE_ACTUALIZADO, ENTREGAR_DINERO,
      output PIN_INCORRECTO, FONDOS_INSUFICIENTES,
      output LIMITE_EXCEDIDO, ADVERTENCIA, BLOQUEO, BALANCE
   );

endinterface

// File: rtl/cajero_param_detector_flanco.sv
// detector_flanco: registered rising-edge detector for keypad strobes.
// History resets high so a strobe already held through reset is no edge.
module detector_flanco (
   input  logic clock,
   input  logic reset,
   input  logic entrada,
   output logic flanco
);

   logic previo;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         previo <= 1'b1;
         flanco <= 1'b0;
      end else begin
         previo <= entrada;
         flanco <= entrada & ~previo;
      end
   end

endmodule

// File: rtl/cajero_param.sv
// cajero_param: ATM transaction controller with PIN check, attempt
// lock-out, saturating deposits and optional per-session withdrawal cap.
module cajero_param
   import cajero_pkg::*;
#(
   parameter int N_DIGITOS     = 4,
   parameter int MAX_INTENTOS  = 3,
   parameter int ANCHO_MONTO   = 32,
   parameter int ANCHO_BALANCE = 64,
   parameter logic [ANCHO_BALANCE-1:0] BALANCE_INICIAL =
      ANCHO_BALANCE'(10000),
   parameter logic [ANCHO_BALANCE:0] LIMITE_RETIRO = '0
) (
   input  logic           clock,
   input  logic           reset,
   cajero_param_if.slave  bus
);

   localparam int AP = 4 * N_DIGITOS;
   localparam int AC = $clog2(N_DIGITOS + 1);
   localparam int AI = $clog2(MAX_INTENTOS + 1);
   localparam int AB = ANCHO_BALANCE;

   estado_t                estado, estado_d;
   logic [AP-1:0]          pin_ref, pin_ref_d;
   logic [AP-1:0]          pin_in, pin_in_d;
   logic [AC-1:0]          cnt, cnt_d;
   logic [AI-1:0]          intentos, intentos_d;
   logic [AI-1:0]          intentos_inc;
   logic                   adv, adv_d;
   logic                   bloq, bloq_d;
   logic [ANCHO_MONTO-1:0] monto_q, monto_d;
   logic                   tipo_q, tipo_d;
   logic [AB-1:0]          balance, balance_d;
   logic [AB:0]            sesion, sesion_d;
   logic                   upd, upd_d;
   logic                   ent, ent_d;
   logic                   inc, inc_d;
   logic                   ins, ins_d;
   logic                   lim, lim_d;

   logic                   dig_flanco;
   logic                   monto_flanco;
   logic [AB:0]            monto_ext;
   logic [AB:0]            suma_dep;
   logic [AB+1:0]          suma_ses;

   detector_flanco u_flanco_dig (
      .clock   (clock),
      .reset   (reset),
      .entrada (bus.DIGITO_STB),
      .flanco  (dig_flanco)
   );

   detector_flanco u_flanco_monto (
      .clock   (clock),
      .reset   (reset),
      .entrada (bus.MONTO_STB),
      .flanco  (monto_flanco)
   );

   // Widened so neither the deposit nor the cap check can wrap.
   assign monto_ext    = (AB+1)'(monto_q);
   assign suma_dep     = {1'b0, balance} + monto_ext;
   assign suma_ses     = {1'b0, sesion} + (AB+2)'(monto_q);
   assign intentos_inc = intentos + 1'b1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado   <= ESPERA_TARJETA;
         pin_ref  <= '0;
         pin_in   <= '0;
         cnt      <= '0;
         intentos <= '0;
         adv      <= 1'b0;
         bloq     <= 1'b0;
         monto_q  <= '0;
         tipo_q   <= TIPO_DEPOSITO;
         balance  <= BALANCE_INICIAL;
         sesion   <= '0;
         upd      <= 1'b0;
         ent      <= 1'b0;
         inc      <= 1'b0;
         ins      <= 1'b0;
         lim      <= 1'b0;
      end else begin
         estado   <= estado_d;
         pin_ref  <= pin_ref_d;
         pin_in   <= pin_in_d;
         cnt      <= cnt_d;
         intentos <= intentos_d;
         adv      <= adv_d;
         bloq     <= bloq_d;
         monto_q  <= monto_d;
         tipo_q   <= tipo_d;
         balance  <= balance_d;
         sesion   <= sesion_d;
         upd      <= upd_d;
         ent      <= ent_d;
         inc      <= inc_d;
         ins      <= ins_d;
         lim      <= lim_d;
      end
   end

   always_comb begin
      estado_d   = estado;
      pin_ref_d  = pin_ref;
      pin_in_d   = pin_in;
      cnt_d      = cnt;
      intentos_d = intentos;
      adv_d      = adv;
      bloq_d     = bloq;
      monto_d    = monto_q;
      tipo_d     = tipo_q;
      balance_d  = balance;
      sesion_d   = sesion;
      upd_d      = 1'b0;
      ent_d      = 1'b0;
      inc_d      = 1'b0;
      ins_d      = 1'b0;
      lim_d      = 1'b0;

      // Card removal pre-empts every state but lock-out.
      if (estado != BLOQUEADO && !bus.TARGETA_RECIBIDA) begin
         estado_d = ESPERA_TARJETA;
      end else begin
         unique case (estado)
            ESPERA_TARJETA: begin
               pin_ref_d = bus.PIN;
               pin_in_d  = '0;
               cnt_d     = '0;
               sesion_d  = '0;
               estado_d  = LEER_PIN;
            end
            LEER_PIN: begin
               if (dig_flanco) begin
                  pin_in_d = AP'({pin_in, bus.DIGITO});
                  cnt_d    = cnt + 1'b1;
                  if (cnt == AC'(N_DIGITOS - 1))
                     estado_d = VERIFICAR_PIN;
               end
            end
            VERIFICAR_PIN: begin
               pin_in_d = '0;
               cnt_d    = '0;
               if (pin_in == pin_ref) begin
                  intentos_d = '0;
                  adv_d      = 1'b0;
                  estado_d   = ESPERA_MONTO;
               end else begin
                  intentos_d = intentos_inc;
                  inc_d      = 1'b1;
                  if (intentos_inc == AI'(MAX_INTENTOS)) begin
                     bloq_d   = 1'b1;
                     estado_d = BLOQUEADO;
                  end else begin
                     if (intentos_inc == AI'(MAX_INTENTOS - 1))
                        adv_d = 1'b1;
                     estado_d = LEER_PIN;
                  end
               end
            end
            ESPERA_MONTO: begin
               if (monto_flanco) begin
                  monto_d  = bus.MONTO;
                  tipo_d   = bus.TIPO_TRANS;
                  estado_d = TRANSACCION;
               end
            end
            TRANSACCION: begin
               estado_d = ESPERA_MONTO;
               unique case (tipo_q)
                  TIPO_DEPOSITO: begin
                     upd_d = 1'b1;
                     if (suma_dep[AB])
                        balance_d = '1;
                     else
                        balance_d = suma_dep[AB-1:0];
                  end
                  TIPO_RETIRO: begin
                     if (monto_ext > {1'b0, balance}) begin
                        ins_d = 1'b1;
                     end else if (LIMITE_RETIRO != '0 &&
                                  suma_ses > {1'b0, LIMITE_RETIRO}) begin
                        lim_d = 1'b1;
                     end else begin
                        balance_d = balance - monto_ext[AB-1:0];
                        sesion_d  = suma_ses[AB+1] ? '1 : suma_ses[AB:0];
                        ent_d     = 1'b1;
                        upd_d     = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            BLOQUEADO: begin
               estado_d = BLOQUEADO;
            end
            default: begin
               estado_d = ESPERA_TARJETA;
            end
         endcase
      end
   end

   assign bus.BALANCE_ACTUALIZADO  = upd;
   assign bus.ENTREGAR_DINERO      = ent;
   assign bus.PIN_INCORRECTO       = inc;
   assign bus.FONDOS_INSUFICIENTES = ins;
   assign bus.LIMITE_EXCEDIDO      = lim;
   assign bus.ADVERTENCIA          = adv;
   assign bus.BLOQUEO              = bloq;
   assign bus.BALANCE              = balance;

endmodule

// File: tb/tb_cajero_param.sv
// tb_cajero_param: directed checks of cajero_param on three parameter sets
// (default, 8000 withdrawal cap, 6-digit PIN with 40-bit balance).
module tb_cajero_param;
   import cajero_pkg::*;

   localparam logic [4:0] P_UPD = 5'b10000;
   localparam logic [4:0] P_ENT = 5'b01000;
   localparam logic [4:0] P_INS = 5'b00100;
   localparam logic [4:0] P_LIM = 5'b00010;
   localparam logic [4:0] P_INC = 5'b00001;
   localparam logic [4:0] P_NO  = 5'b00000;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;

   logic        card_ab, dstb_ab, mstb_ab, tipo_ab;
   logic [3:0]  dig_ab;
   logic [31:0] monto_ab;
   logic        card_c, dstb_c, mstb_c, tipo_c;
   logic [3:0]  dig_c;
   logic [31:0] monto_c;

   cajero_param_if #(.N_DIGITOS(4), .ANCHO_MONTO(32), .ANCHO_BALANCE(64)) bus_a ();
   cajero_param_if #(.N_DIGITOS(4), .ANCHO_MONTO(32), .ANCHO_BALANCE(64)) bus_b ();
   cajero_param_if #(.N_DIGITOS(6), .ANCHO_MONTO(32), .ANCHO_BALANCE(40)) bus_c ();

   cajero_param #(
      .N_DIGITOS(4), .MAX_INTENTOS(3), .ANCHO_MONTO(32), .ANCHO_BALANCE(64),
      .BALANCE_INICIAL(64'd10000), .LIMITE_RETIRO(65'd0)
   ) dut_a (.clock(clock), .reset(reset), .bus(bus_a));

   cajero_param #(
      .N_DIGITOS(4), .MAX_INTENTOS(3), .ANCHO_MONTO(32), .ANCHO_BALANCE(64),
      .BALANCE_INICIAL(64'd10000), .LIMITE_RETIRO(65'd8000)
   ) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

   cajero_param #(
      .N_DIGITOS(6), .MAX_INTENTOS(3), .ANCHO_MONTO(32), .ANCHO_BALANCE(40),
      .BALANCE_INICIAL(40'd10000), .LIMITE_RETIRO(41'd0)
   ) dut_c (.clock(clock), .reset(reset), .bus(bus_c));

   assign bus_a.TARGETA_RECIBIDA = card_ab;
   assign bus_a.PIN        = 16'h6969;
   assign bus_a.DIGITO     = dig_ab;
   assign bus_a.DIGITO_STB = dstb_ab;
   assign bus_a.TIPO_TRANS = tipo_ab;
   assign bus_a.MONTO      = monto_ab;
   assign bus_a.MONTO_STB  = mstb_ab;

   assign bus_b.TARGETA_RECIBIDA = card_ab;
   assign bus_b.PIN        = 16'h6969;
   assign bus_b.DIGITO     = dig_ab;
   assign bus_b.DIGITO_STB = dstb_ab;
   assign bus_b.TIPO_TRANS = tipo_ab;
   assign bus_b.MONTO      = monto_ab;
   assign bus_b.MONTO_STB  = mstb_ab;

   assign bus_c.TARGETA_RECIBIDA = card_c;
   assign bus_c.PIN        = 24'h123456;
   assign bus_c.DIGITO     = dig_c;
   assign bus_c.DIGITO_STB = dstb_c;
   assign bus_c.TIPO_TRANS = tipo_c;
   assign bus_c.MONTO      = monto_c;
   assign bus_c.MONTO_STB  = mstb_c;

   logic [4:0] pul_a, pul_b, pul_c;
   assign pul_a = {bus_a.BALANCE_ACTUALIZADO, bus_a.ENTREGAR_DINERO,
                   bus_a.FONDOS_INSUFICIENTES, bus_a.LIMITE_EXCEDIDO,
                   bus_a.PIN_INCORRECTO};
   assign pul_b = {bus_b.BALANCE_ACTUALIZADO, bus_b.ENTREGAR_DINERO,
                   bus_b.FONDOS_INSUFICIENTES, bus_b.LIMITE_EXCEDIDO,
                   bus_b.PIN_INCORRECTO};
   assign pul_c = {bus_c.BALANCE_ACTUALIZADO, bus_c.ENTREGAR_DINERO,
                   bus_c.FONDOS_INSUFICIENTES, bus_c.LIMITE_EXCEDIDO,
                   bus_c.PIN_INCORRECTO};

   typedef struct {
      logic        tipo;
      logic [31:0] monto;
      logic [4:0]  pa;
      logic [63:0] ba;
      logic [4:0]  pb;
      logic [63:0] bb;
   } vec_t;

   vec_t tabla [7];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic tarjeta(input bit c, input logic v);
      if (c) card_c = v;
      else card_ab = v;
      tick;
   endtask

   // Strobe one cycle; accepted on the 2nd edge, result after the 3rd.
   task automatic digito(input bit c, input logic [3:0] d);
      if (c) begin dig_c = d; dstb_c = 1'b1; end
      else begin dig_ab = d; dstb_ab = 1'b1; end
      tick;
      dstb_c  = 1'b0;
      dstb_ab = 1'b0;
      tick;
      tick;
   endtask

   task automatic pin4(input logic [15:0] p);
      for (int i = 3; i >= 0; i--) digito(1'b0, p[i*4 +: 4]);
   endtask

   task automatic monto(input bit c, input logic t, input logic [31:0] m);
      if (c) begin tipo_c = t; monto_c = m; mstb_c = 1'b1; end
      else begin tipo_ab = t; monto_ab = m; mstb_ab = 1'b1; end
      tick;
      mstb_c  = 1'b0;
      mstb_ab = 1'b0;
      tick;
      tick;
   endtask

   task automatic nueva_sesion;
      tarjeta(1'b0, 1'b0);
      tarjeta(1'b0, 1'b1);
   endtask

   logic [40:0] exp_c;

   initial begin
      tabla[0] = '{TIPO_DEPOSITO, 32'd5000,  P_UPD,         64'd15000,
                                             P_UPD,         64'd15000};
      tabla[1] = '{TIPO_RETIRO,   32'd5000,  P_UPD | P_ENT, 64'd10000,
                                             P_UPD | P_ENT, 64'd10000};
      tabla[2] = '{TIPO_RETIRO,   32'd20000, P_INS,         64'd10000,
                                             P_INS,         64'd10000};
      tabla[3] = '{TIPO_RETIRO,   32'd4000,  P_UPD | P_ENT, 64'd6000,
                                             P_LIM,         64'd10000};
      tabla[4] = '{TIPO_RETIRO,   32'd3000,  P_UPD | P_ENT, 64'd3000,
                                             P_UPD | P_ENT, 64'd7000};
      tabla[5] = '{TIPO_RETIRO,   32'd0,     P_UPD | P_ENT, 64'd3000,
                                             P_UPD | P_ENT, 64'd7000};
      tabla[6] = '{TIPO_RETIRO,   32'd3001,  P_INS,         64'd3000,
                                             P_LIM,         64'd7000};

      // Card and digit strobe already high during reset.
      reset = 1'b1;
      card_ab = 1'b1; dstb_ab = 1'b1; dig_ab = 4'd9;
      mstb_ab = 1'b0; tipo_ab = 1'b0; monto_ab = '0;
      card_c = 1'b0; dstb_c = 1'b0; dig_c = '0;
      mstb_c = 1'b0; tipo_c = 1'b0; monto_c = '0;
      tick;
      chk("rst_pulses_a", 64'(pul_a), 64'(P_NO));
      chk("rst_adv_a", 64'(bus_a.ADVERTENCIA), 64'd0);
      chk("rst_bloq_a", 64'(bus_a.BLOQUEO), 64'd0);
      chk("rst_bal_a", bus_a.BALANCE, 64'd10000);
      chk("rst_bal_c", 64'(bus_c.BALANCE), 64'd10000);
      reset = 1'b0;
      tick; tick; tick;
      dstb_ab = 1'b0;
      tick;
      pin4(16'h6969);
      chk("pin_ok_a", 64'(pul_a), 64'(P_NO));
      chk("pin_ok_b", 64'(pul_b), 64'(P_NO));

      foreach (tabla[i]) begin
         monto(1'b0, tabla[i].tipo, tabla[i].monto);
         chk($sformatf("tab%0d_pul_a", i), 64'(pul_a), 64'(tabla[i].pa));
         chk($sformatf("tab%0d_bal_a", i), bus_a.BALANCE, tabla[i].ba);
         chk($sformatf("tab%0d_pul_b", i), 64'(pul_b), 64'(tabla[i].pb));
         chk($sformatf("tab%0d_bal_b", i), bus_b.BALANCE, tabla[i].bb);
      end
      tick;
      chk("pulse_one_cycle_a", 64'(pul_a), 64'(P_NO));

      // New session resets the cap accumulator.
      nueva_sesion;
      pin4(16'h6969);
      monto(1'b0, TIPO_RETIRO, 32'd4000);
      chk("resesion_pul_a", 64'(pul_a), 64'(P_INS));
      chk("resesion_bal_a", bus_a.BALANCE, 64'd3000);
      chk("resesion_pul_b", 64'(pul_b), 64'(P_UPD | P_ENT));
      chk("resesion_bal_b", bus_b.BALANCE, 64'd3000);

      // Removal on the acceptance edge drops the deposit.
      tipo_ab = TIPO_DEPOSITO; monto_ab = 32'd1000; mstb_ab = 1'b1;
      tick;
      card_ab = 1'b0; mstb_ab = 1'b0;
      tick;
      tick;
      chk("remove_wins_pul", 64'(pul_a), 64'(P_NO));
      tarjeta(1'b0, 1'b1);
      pin4(16'h6969);
      tick;
      chk("remove_wins_bal", bus_a.BALANCE, 64'd3000);

      // Held strobe counts once.
      nueva_sesion;
      dig_ab = 4'd6; dstb_ab = 1'b1;
      repeat (5) tick;
      dstb_ab = 1'b0;
      tick; tick;
      digito(1'b0, 4'd9);
      digito(1'b0, 4'd6);
      digito(1'b0, 4'd9);
      chk("held_strobe_pin", 64'(pul_a), 64'(P_NO));
      monto(1'b0, TIPO_DEPOSITO, 32'd100);
      chk("held_strobe_dep", 64'(pul_a), 64'(P_UPD));
      chk("held_strobe_bal", bus_a.BALANCE, 64'd3100);

      // Partial digits discarded on removal.
      nueva_sesion;
      digito(1'b0, 4'd4);
      digito(1'b0, 4'd4);
      nueva_sesion;
      pin4(16'h6969);
      chk("partial_pin", 64'(pul_a), 64'(P_NO));
      monto(1'b0, TIPO_DEPOSITO, 32'd100);
      chk("partial_dep", 64'(pul_b), 64'(P_UPD));
      chk("partial_bal", bus_b.BALANCE, 64'd3200);

      // Correct PIN clears the attempt count.
      nueva_sesion;
      pin4(16'h4444);
      chk("wrong1_pul", 64'(pul_a), 64'(P_INC));
      chk("wrong1_adv", 64'(bus_a.ADVERTENCIA), 64'd0);
      pin4(16'h6969);
      chk("clear_pul", 64'(pul_a), 64'(P_NO));
      nueva_sesion;
      pin4(16'h4444);
      chk("wrongA_pul", 64'(pul_a), 64'(P_INC));
      chk("wrongA_adv", 64'(bus_a.ADVERTENCIA), 64'd0);
      pin4(16'h4444);
      chk("wrongB_pul", 64'(pul_a), 64'(P_INC));
      chk("wrongB_adv", 64'(bus_a.ADVERTENCIA), 64'd1);
      chk("wrongB_bloq", 64'(bus_a.BLOQUEO), 64'd0);
      nueva_sesion;
      chk("adv_kept", 64'(bus_a.ADVERTENCIA), 64'd1);
      pin4(16'h4444);
      chk("wrongC_pul", 64'(pul_a), 64'(P_INC));
      chk("wrongC_bloq", 64'(bus_a.BLOQUEO), 64'd1);
      chk("wrongC_bloq_b", 64'(bus_b.BLOQUEO), 64'd1);
      pin4(16'h6969);
      chk("locked_pin", 64'(pul_a), 64'(P_NO));
      tarjeta(1'b0, 1'b0);
      monto(1'b0, TIPO_DEPOSITO, 32'd500);
      chk("locked_dep", 64'(pul_a), 64'(P_NO));
      chk("locked_bal", bus_a.BALANCE, 64'd3200);
      chk("locked_bloq", 64'(bus_a.BLOQUEO), 64'd1);

      // Asynchronous reset mid-operation.
      reset = 1'b1;
      #1;
      chk("async_bloq", 64'(bus_a.BLOQUEO), 64'd0);
      chk("async_adv", 64'(bus_a.ADVERTENCIA), 64'd0);
      chk("async_bal", bus_a.BALANCE, 64'd10000);
      tick;
      reset = 1'b0;
      tick;

      // 6-digit PIN, 40-bit balance saturation.
      tarjeta(1'b1, 1'b1);
      for (int i = 1; i <= 6; i++) digito(1'b1, 4'(i));
      chk("c_pin_ok", 64'(pul_c), 64'(P_NO));
      exp_c = 41'd10000;
      for (int i = 0; i < 260; i++) begin
         monto(1'b1, TIPO_DEPOSITO, 32'hFFFF_FFFF);
         exp_c = exp_c + 41'h0_FFFF_FFFF;
         if (exp_c[40]) exp_c = {1'b0, 40'hFF_FFFF_FFFF};
         chk($sformatf("c_dep%0d_pul", i), 64'(pul_c), 64'(P_UPD));
         chk($sformatf("c_dep%0d_bal", i), 64'(bus_c.BALANCE),
             64'(exp_c[39:0]));
      end
      chk("c_saturated", 64'(bus_c.BALANCE), 64'h00FF_FFFF_FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cajero_param.md
# cajero_param

Parametrised ATM transaction controller, next generation of the fixed 4-digit/32-bit cajero. Takes a card-present flag, a reference PIN, keypad digits and amount requests, verifies the PIN with a configurable attempt limit, and executes deposits and withdrawals against an internal balance. Supports multiple transactions per card session and enforces an optional per-session withdrawal limit. Sits between the keypad/card front end and the cash dispenser.

## Interface
- N_DIGITOS, 4: PIN length in BCD digits.
- MAX_INTENTOS, 3: wrong PINs before lock-out, ≥2.
- ANCHO_MONTO, 32: amount width.
- ANCHO_BALANCE, 64: balance width, ≥ ANCHO_MONTO.
- BALANCE_INICIAL, 10000: balance after reset.
- LIMITE_RETIRO, 0: per-session withdrawal cap; 0 disables.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- TARGETA_RECIBIDA  in  1  card present, level.
- PIN  in  4*N_DIGITOS  reference PIN, first digit in MS nibble; sampled on card insertion.
- DIGITO  in  4  keypad digit.
- DIGITO_STB  in  1  digit strobe.
- TIPO_TRANS  in  1  0 deposit, 1 withdrawal; sampled with amount.
- MONTO  in  ANCHO_MONTO  amount.
- MONTO_STB  in  1  amount strobe.
- BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO, FONDOS_INSUFICIENTES, LIMITE_EXCEDIDO  out  1 each  one-cycle pulses.
- ADVERTENCIA  out  1  level: one attempt left.
- BLOQUEO  out  1  level: locked.
- BALANCE  out  ANCHO_BALANCE  current balance.

## Operation
- States: ESPERA_TARJETA, LEER_PIN, VERIFICAR_PIN, ESPERA_MONTO, TRANSACCION, BLOQUEADO. Reset → ESPERA_TARJETA.
- Strobes are edge-detected: one acceptance per 0→1 transition, however long held; strobe high during reset counts as no edge.
- ESPERA_TARJETA: TARGETA_RECIBIDA=1 → latch PIN, clear digit counter and session accumulator, → LEER_PIN.
- LEER_PIN: each DIGITO_STB edge shifts DIGITO in (first digit ends MS); N_DIGITOS-th digit → VERIFICAR_PIN.
- VERIFICAR_PIN: match → clear attempts, drop ADVERTENCIA, → ESPERA_MONTO. Mismatch → attempts+1, PIN_INCORRECTO pulse; attempts = MAX_INTENTOS-1 → ADVERTENCIA=1, → LEER_PIN; attempts = MAX_INTENTOS → BLOQUEADO; else → LEER_PIN.
- ESPERA_MONTO: MONTO_STB edge latches MONTO, TIPO_TRANS → TRANSACCION.
- TRANSACCION deposit: BALANCE += MONTO (zero-extended), saturating at all-ones; BALANCE_ACTUALIZADO pulse.
- TRANSACCION withdrawal, first match wins: MONTO > BALANCE → FONDOS_INSUFICIENTES; LIMITE_RETIRO≠0 and session+MONTO > LIMITE_RETIRO → LIMITE_EXCEDIDO; else BALANCE −= MONTO, session += MONTO, ENTREGAR_DINERO and BALANCE_ACTUALIZADO pulse together.
- TRANSACCION always → ESPERA_MONTO (one cycle).
- Session accumulator ANCHO_BALANCE+1 bits; comparisons never wrap.
- TARGETA_RECIBIDA=0 in any state except BLOQUEADO → ESPERA_TARJETA next edge, partial digits discarded; attempts and ADVERTENCIA kept.
- BLOQUEADO: BLOQUEO=1, all inputs ignored; exit only by reset.
- Strobe of the wrong kind for the state is ignored and not queued.

## Timing
- All outputs registered; reset values: all pulses 0, ADVERTENCIA 0, BLOQUEO 0, BALANCE = BALANCE_INICIAL, attempts 0.
- Edge accepting last digit = k: PIN result/pulse visible after edge k+1.
- Amount strobe accepted at k: result pulses and new BALANCE visible after k+1; next amount accepted from k+2.
- Card removal same cycle as strobe edge: removal wins, strobe dropped.
- BLOQUEO rises on edge k+1 with the last PIN_INCORRECTO pulse.
- Reset mid-operation: all state cleared immediately, asynchronously.

## Structure
- Shared package cajero_pkg: state encoding constants, TIPO_DEPOSITO/TIPO_RETIRO.
- Sub-module detector_flanco (registered rising-edge detector, async reset), instantiated for DIGITO_STB and MONTO_STB.

## Test plan
- PIN 16'h6969, digits 6,9,6,9; deposit 5000 → BALANCE_ACTUALIZADO, BALANCE 15000; withdrawal 5000 → ENTREGAR_DINERO, BALANCE 10000.
- Digits 4,4,4,4 twice → two PIN_INCORRECTO, ADVERTENCIA=1 after second; third wrong → BLOQUEO=1; later correct PIN ignored until reset.
- Withdrawal 20000 with BALANCE 10000 → FONDOS_INSUFICIENTES, BALANCE unchanged.
- LIMITE_RETIRO=8000: withdraw 5000 OK, then 4000 → LIMITE_EXCEDIDO; reinsert card, 4000 → ENTREGAR_DINERO.
- DIGITO_STB held 5 cycles → one digit; card removed after 2 digits, reinsert, full correct PIN → ESPERA_MONTO.
- N_DIGITOS=6, ANCHO_BALANCE=40, deposit 32'hFFFFFFFF repeatedly → saturates at 40'hFFFFFFFFFF.
